// File: rtl/accumulator_drain_pkg.sv
// Shared types for the accumulator read-out engine.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } drain_state_e;

    // One entry per outstanding accumulator read; 'last' marks the final word.
    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/accumulator_drain_sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH need not be a power of two.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; callers never push when full or pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/accumulator_drain.sv
// Sweeps an address range through the accumulator read port, streams the words out on
// valid/ready, and optionally zeroes each word right after it has been read.
module accumulator_drain
    import acc_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [DATA_WIDTH-1:0] acc_rd_data,
    output logic                  acc_wr_en,
    output logic                  acc_wr_we,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic [DATA_WIDTH-1:0] acc_wr_wdata,
    output logic                  acc_mode,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LEN_W      = ADDR_WIDTH + 1;

    drain_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_W-1:0]        remain_q;
    logic                    clear_q;
    rd_tag_t [RD_LAT-1:0]    tag_pipe;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_WIDTH:0]     fifo_dout;
    logic                    fifo_empty;
    logic                    credit_ok;
    logic                    last_issue;
    logic                    issue;
    logic                    pop;

    // Count reads still travelling through the RAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + CNT_W'(tag_pipe[i].valid);
    end

    // Every word already requested has a guaranteed FIFO slot, so the FIFO cannot overflow.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign last_issue = (remain_q == LEN_W'(1));

    // Next-state and read-issue decode.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = (len == '0) ? DONE : ISSUE;
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && last_issue) state_d = WAIT;
            end
            WAIT:  if (m_valid && m_ready && m_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Address / remaining-word counters; address wraps naturally at the RAM top.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            clear_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            addr_q   <= base_addr;
            remain_q <= len;
            clear_q  <= clear;
        end else if (issue) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
        end
    end

    // Tag shift register mirrors the RAM read latency; reset drops any returning data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0].valid <= issue;
            tag_pipe[0].last  <= issue && last_issue;
            for (int i = 1; i < RD_LAT; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Clear write trails its read by one cycle, so the read sees the pre-clear value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q <= issue && clear_q;
            if (issue) wr_addr_q <= addr_q;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_pipe[RD_LAT-1].valid),
        .din   ({tag_pipe[RD_LAT-1].last, acc_rd_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pop          = m_valid && m_ready;
    assign m_valid      = !fifo_empty;
    assign m_data       = m_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign m_last       = m_valid && fifo_dout[DATA_WIDTH];

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign acc_rd_en    = issue;
    assign acc_rd_addr  = addr_q;
    assign acc_wr_en    = wr_en_q;
    assign acc_wr_we    = wr_en_q;
    assign acc_wr_addr  = wr_addr_q;
    assign acc_wr_wdata = '0;
    assign acc_mode     = 1'b0;

endmodule
